// File: rtl/ram_fifo_pkg.sv
// Shared parameters and grant-side encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DW    = 4;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        GRANT_PUSH = 1'b0,
        GRANT_POP  = 1'b1
    } grant_side_e;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// FIFO client handshake plus external single-port RAM bus, bundled for the controller.
interface ram_fifo_ctrl_if #(
    parameter int unsigned DW = ram_fifo_pkg::DW,
    parameter int unsigned AW = ram_fifo_pkg::AW
);

    logic          push;
    logic [DW-1:0] push_data;
    logic          push_ack;
    logic          pop;
    logic          pop_ack;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;

    logic          ram_cs;
    logic          ram_write;
    logic          ram_read;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // master: FIFO client together with the RAM model that returns ram_rdata
    modport master (
        output push, push_data, pop, ram_rdata,
        input  push_ack, pop_ack, pop_data, pop_valid, full, empty, count,
        input  ram_cs, ram_write, ram_read, ram_addr, ram_wdata
    );

    modport slave (
        input  push, push_data, pop, ram_rdata,
        output push_ack, pop_ack, pop_data, pop_valid, full, empty, count,
        output ram_cs, ram_write, ram_read, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ram_fifo_arb.sv
// Push/pop arbiter for the single RAM port; alternates on contention.
module ram_fifo_arb
    import ram_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push_ok,
    input  logic pop_ok,
    output logic push_ack,
    output logic pop_ack
);

    grant_side_e last_grant;
    logic        contend;

    always_comb begin
        push_ack = 1'b0;
        pop_ack  = 1'b0;
        contend  = push_ok & pop_ok;
        if (contend) begin
            if (last_grant == GRANT_PUSH) begin
                pop_ack = 1'b1;
            end else begin
                push_ack = 1'b1;
            end
        end else begin
            push_ack = push_ok;
            pop_ack  = pop_ok;
        end
    end

    // only contended cycles move the fairness flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_PUSH;
        end else if (contend) begin
            last_grant <= pop_ack ? GRANT_POP : GRANT_PUSH;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving one external single-port synchronous RAM, one access per cycle.
module ram_fifo_ctrl #(
    parameter int unsigned DW = ram_fifo_pkg::DW,
    parameter int unsigned AW = ram_fifo_pkg::AW
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_fifo_ctrl_if.slave bus
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(1) << AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;
    logic          push_ack;
    logic          pop_ack;

    // rst_n gates eligibility so no grant or RAM strobe escapes while in reset
    always_comb begin
        full    = (count == FULL_COUNT);
        empty   = (count == '0);
        push_ok = rst_n & bus.push & ~full;
        pop_ok  = rst_n & bus.pop & ~empty;
    end

    ram_fifo_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_ok  (push_ok),
        .pop_ok   (pop_ok),
        .push_ack (push_ack),
        .pop_ack  (pop_ack)
    );

    always_comb begin
        bus.push_ack  = push_ack;
        bus.pop_ack   = pop_ack;
        bus.pop_valid = pop_valid;
        bus.pop_data  = bus.ram_rdata;
        bus.full      = full;
        bus.empty     = empty;
        bus.count     = count;
        bus.ram_cs    = rst_n;
        bus.ram_write = push_ack;
        bus.ram_read  = pop_ack;
        bus.ram_addr  = rd_ptr;
        bus.ram_wdata = '0;
        if (push_ack) begin
            bus.ram_addr  = wr_ptr;
            bus.ram_wdata = bus.push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_ack;
            if (push_ack) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ack) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ack && !pop_ack) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ack && !push_ack) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    a_single_access: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_ack && pop_ack));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= FULL_COUNT);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 256x4 RAM and a queue scoreboard.
module tb_ram_fifo_ctrl;

    localparam int unsigned TDW    = 4;
    localparam int unsigned TAW    = 8;
    localparam int unsigned TDEPTH = 256;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DW(TDW), .AW(TAW)) bus ();

    ram_fifo_ctrl #(.DW(TDW), .AW(TAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [TDW-1:0] mem [TDEPTH];
    logic [TDW-1:0] rdata_q = '0;

    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_wdata;
            if (bus.ram_read)  rdata_q <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_rdata = rdata_q;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: model FIFO contents, expected pop data awaiting pop_valid
    logic [TDW-1:0] model_q [$];
    logic [TDW-1:0] exp_q [$];
    logic [TDW-1:0] exp_d;
    logic [TAW-1:0] m_wr;
    logic [TAW-1:0] m_rd;
    logic           m_last_pop;
    logic           prev_pop;
    logic           m_push_ok;
    logic           m_pop_ok;
    logic           e_push;
    logic           e_pop;

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            chk("rst_pop_valid", 32'(bus.pop_valid), 32'(1'b0));
            chk("rst_count",     32'(bus.count),     32'(0));
            chk("rst_empty",     32'(bus.empty),     32'(1'b1));
            chk("rst_full",      32'(bus.full),      32'(1'b0));
            chk("rst_ram_cs",    32'(bus.ram_cs),    32'(1'b0));
            chk("rst_ram_write", 32'(bus.ram_write), 32'(1'b0));
            chk("rst_ram_read",  32'(bus.ram_read),  32'(1'b0));
            chk("rst_push_ack",  32'(bus.push_ack),  32'(1'b0));
            chk("rst_pop_ack",   32'(bus.pop_ack),   32'(1'b0));
            model_q.delete();
            exp_q.delete();
            m_wr       = '0;
            m_rd       = '0;
            m_last_pop = 1'b0;
            prev_pop   = 1'b0;
        end else begin
            chk("pop_valid", 32'(bus.pop_valid), 32'(prev_pop));
            if (prev_pop) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got pop_valid with no expected data at %0t", $time);
                end else begin
                    exp_d = exp_q.pop_front();
                    chk("pop_data", 32'(bus.pop_data), 32'(exp_d));
                end
            end
            chk("count", 32'(bus.count), 32'(model_q.size()));
            chk("empty", 32'(bus.empty), 32'(model_q.size() == 0));
            chk("full",  32'(bus.full),  32'(model_q.size() == TDEPTH));

            m_push_ok = bus.push && (model_q.size() < TDEPTH);
            m_pop_ok  = bus.pop && (model_q.size() > 0);
            if (m_push_ok && m_pop_ok) begin
                e_pop      = !m_last_pop;
                e_push     = m_last_pop;
                m_last_pop = e_pop;
            end else begin
                e_push = m_push_ok;
                e_pop  = m_pop_ok;
            end
            chk("push_ack",  32'(bus.push_ack),  32'(e_push));
            chk("pop_ack",   32'(bus.pop_ack),   32'(e_pop));
            chk("ram_cs",    32'(bus.ram_cs),    32'(1'b1));
            chk("ram_write", 32'(bus.ram_write), 32'(e_push));
            chk("ram_read",  32'(bus.ram_read),  32'(e_pop));
            if (e_push) begin
                chk("wr_addr",  32'(bus.ram_addr),  32'(m_wr));
                chk("wr_wdata", 32'(bus.ram_wdata), 32'(bus.push_data));
                model_q.push_back(bus.push_data);
                m_wr = m_wr + 8'd1;
            end else if (e_pop) begin
                chk("rd_addr", 32'(bus.ram_addr), 32'(m_rd));
                exp_q.push_back(model_q.pop_front());
                m_rd = m_rd + 8'd1;
            end else begin
                chk("idle_addr",  32'(bus.ram_addr),  32'(m_rd));
                chk("idle_wdata", 32'(bus.ram_wdata), 32'(0));
            end
            prev_pop = e_pop;
        end
    end

    typedef struct {
        logic           push;
        logic [TDW-1:0] data;
        logic           pop;
        logic           exp_push_ack;
        logic           exp_pop_ack;
        int unsigned    exp_cnt;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vec [NVEC];

    function automatic vec_t mk(input logic p, input logic [TDW-1:0] d, input logic q,
                                input logic ea, input logic eb, input int unsigned c);
        vec_t v;
        v.push = p;  v.data = d;  v.pop = q;
        v.exp_push_ack = ea;  v.exp_pop_ack = eb;  v.exp_cnt = c;
        return v;
    endfunction

    task automatic drive(input logic p, input logic [TDW-1:0] d, input logic q);
        @(negedge clk);
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = q;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.pop       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.pop       = 1'b0;

        // pop on empty, 3/7/A round trip, push-only-eligible contention, then alternating grants at count 5
        vec[0]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 0);
        vec[1]  = mk(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 0);
        vec[2]  = mk(1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1);
        vec[3]  = mk(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 2);
        vec[4]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3);
        vec[5]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2);
        vec[6]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1);
        vec[7]  = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 0);
        vec[8]  = mk(1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 0);
        vec[9]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1);
        vec[10] = mk(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 0);
        vec[11] = mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1);
        vec[12] = mk(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2);
        vec[13] = mk(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 3);
        vec[14] = mk(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 4);
        vec[15] = mk(1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 5);
        vec[16] = mk(1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 4);
        vec[17] = mk(1'b1, 4'hD, 1'b1, 1'b0, 1'b1, 5);
        vec[18] = mk(1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 4);
        vec[19] = mk(1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 5);
        vec[20] = mk(1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 4);
        vec[21] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 5);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(vec[i].push, vec[i].data, vec[i].pop);
            #2;
            chk("vec_push_ack", 32'(bus.push_ack), 32'(vec[i].exp_push_ack));
            chk("vec_pop_ack",  32'(bus.pop_ack),  32'(vec[i].exp_pop_ack));
            chk("vec_count",    32'(bus.count),    vec[i].exp_cnt);
        end

        // fill to 256, reject the 257th push, contention when full goes to pop, drain in order
        do_reset();
        for (int i = 0; i < 256; i++) drive(1'b1, 4'(i), 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        #2;
        chk("fill_full",  32'(bus.full),  32'(1'b1));
        chk("fill_count", 32'(bus.count), 32'(256));
        drive(1'b1, 4'h5, 1'b0);
        #2;
        chk("over_push_ack",  32'(bus.push_ack),  32'(1'b0));
        chk("over_ram_write", 32'(bus.ram_write), 32'(1'b0));
        drive(1'b1, 4'h5, 1'b1);
        #2;
        chk("full_contend_pop",  32'(bus.pop_ack),  32'(1'b1));
        chk("full_contend_push", 32'(bus.push_ack), 32'(1'b0));
        for (int i = 0; i < 255; i++) drive(1'b0, 4'h0, 1'b1);
        drive(1'b0, 4'h0, 1'b0);
        #2;
        chk("drain_empty", 32'(bus.empty), 32'(1'b1));

        // pointer wrap: 200 in, 200 out, 100 in leaves wr_ptr at 44
        do_reset();
        for (int i = 0; i < 200; i++) drive(1'b1, 4'(i * 3), 1'b0);
        for (int i = 0; i < 200; i++) drive(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 100; i++) drive(1'b1, 4'(i + 7), 1'b0);
        drive(1'b1, 4'hE, 1'b0);
        #2;
        chk("wrap_wr_addr", 32'(bus.ram_addr), 32'(44));
        for (int i = 0; i < 101; i++) drive(1'b0, 4'h0, 1'b1);
        drive(1'b0, 4'h0, 1'b0);

        // reset the cycle after a pop_ack, then grant on the first cycle out of reset
        drive(1'b1, 4'h1, 1'b0);
        drive(1'b1, 4'h2, 1'b0);
        drive(1'b0, 4'h0, 1'b1);
        #2;
        chk("pre_rst_pop_ack", 32'(bus.pop_ack), 32'(1'b1));
        @(negedge clk);
        rst_n    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #2;
        chk("midrst_pop_valid", 32'(bus.pop_valid), 32'(1'b0));
        chk("midrst_count",     32'(bus.count),     32'(0));
        chk("midrst_empty",     32'(bus.empty),     32'(1'b1));
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        bus.push      = 1'b1;
        bus.push_data = 4'h5;
        #2;
        chk("first_grant_push_ack", 32'(bus.push_ack), 32'(1'b1));
        drive(1'b0, 4'h0, 1'b1);
        drive(1'b0, 4'h0, 1'b0);
        repeat (3) drive(1'b0, 4'h0, 1'b0);
        #2;
        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DW, default 4: data width; matches the 256x4 RAM word.
REQ-002 Parameter AW, default 8: address width; depth = 2**AW = 256.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port push  input  1: request to write push_data into the FIFO.
REQ-006 Port push_data  input  DW: write data.
REQ-007 Port push_ack  output  1: push granted this cycle (combinational).
REQ-008 Port pop  input  1: request to read the oldest entry.
REQ-009 Port pop_ack  output  1: pop granted this cycle (combinational).
REQ-010 Port pop_data  output  DW: read data; equals ram_rdata; qualified by pop_valid.
REQ-011 Port pop_valid  output  1: registered; high the cycle after a granted pop.
REQ-012 Port full / empty  output  1 each: count==256 / count==0.
REQ-013 Port count  output  AW+1: entries stored, 0..256.
REQ-014 Port ram_cs, ram_write, ram_read  output  1 each: RAM chip select and strobes.
REQ-015 Port ram_addr  output  AW; ram_wdata  output  DW; ram_rdata  input  DW: RAM data_out.

Function
REQ-016 The block SHALL drive one single-port 256x4 synchronous RAM; at most one access (write or read) SHALL occur per cycle.
REQ-017 Eligibility: push_ok = push & ~full; pop_ok = pop & ~empty.
REQ-018 If only one of push_ok/pop_ok is set, that request SHALL be granted.
REQ-019 If both are set, grant SHALL go to the side not granted last time both contended (last_grant flag; reset value selects pop first).
REQ-020 A granted push SHALL assert ram_cs=1, ram_write=1, ram_read=0, ram_addr=wr_ptr, ram_wdata=push_data in the same cycle; wr_ptr increments at the edge.
REQ-021 A granted pop SHALL assert ram_cs=1, ram_read=1, ram_write=0, ram_addr=rd_ptr; rd_ptr increments at the edge; pop_valid=1 next cycle with pop_data = the entry.
REQ-022 With no grant, ram_cs=1, ram_write=0, ram_read=0, ram_addr=rd_ptr, ram_wdata=0; ram_cs is never deasserted outside reset, so RAM output is never zeroed.
REQ-023 Pointers SHALL wrap 255 -> 0 with no extra cycle.
REQ-024 count SHALL increment on a granted push and decrement on a granted pop; it never changes by more than 1 per cycle.
REQ-025 A push when full SHALL be ignored (push_ack=0, no RAM write, no state change); likewise a pop when empty.
REQ-026 A push into an empty FIFO SHALL be poppable from the next cycle (empty drops the edge after the write).
REQ-027 Read latency SHALL be exactly 1 cycle from pop_ack to pop_valid; throughput is 1 access/cycle total.

Reset
REQ-028 While rst_n=0: wr_ptr=0, rd_ptr=0, count=0, last_grant=push-side (so pop wins first contention), pop_valid=0, empty=1, full=0, ram_cs=0, ram_write=0, ram_read=0, push_ack=0, pop_ack=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries and cancel a pending pop_valid; RAM contents are not cleared.
REQ-030 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Structure
REQ-031 A shared package ram_fifo_pkg SHALL hold DW, AW, DEPTH, and the grant-side enumeration (GRANT_PUSH, GRANT_POP).
REQ-032 One sub-module ram_fifo_arb SHALL implement REQ-017..019 (inputs push_ok, pop_ok; outputs push_ack, pop_ack; owns last_grant).
REQ-033 The RAM itself is external; the block has no memory array.

Verification
REQ-034 Reset, push 0x3,0x7,0xA on 3 cycles, then pop 3 -> pop_data 0x3,0x7,0xA with pop_valid each a cycle after pop_ack; empty=1 at end.
REQ-035 Push 256 words 0..F repeating -> full=1, count=256; a 257th push -> push_ack=0, no ram_write.
REQ-036 Pop while empty after reset -> pop_ack=0, ram_read=0, pop_valid stays 0.
REQ-037 With count=5, hold push=1 and pop=1 for 6 cycles -> grants alternate pop,push,pop,push,pop,push; count=5 at end.
REQ-038 Fill 200, pop 200, fill 100 -> wr_ptr wraps past 255 to 44; pops return data in order.
REQ-039 Assert rst_n=0 the cycle after a pop_ack -> pop_valid=0, count=0, empty=1 immediately.
